spi_rx: RTL and testbench

Serial receive block for the SPI link: the receiving counterpart of the team's parallel-load, MSB-first transmit shift register. It samples an external SPI bus (mode 0: SClk idle low, data sampled on SClk rising edge) in the system clock domain, assembles SIZE-bit words MSB first and presents each completed word on a parallel holding register with a valid/read handshake. It sits between the SPI pins and the parallel consumer, and reports overrun and framing errors.

---
 rtl/spi_rx_if.sv | 24 ++
 rtl/spi_rx.sv | 156 +++++++++++++++
 tb/tb_spi_rx.sv | 326 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/spi_rx_if.sv
// SPI receive pins plus the parallel word handshake toward the consumer.
interface spi_rx_if #(
   parameter int SIZE = 8
);
   logic            SClk;
   logic            Cs_n;
   logic            SerIn;
   logic            Rd;
   logic [SIZE-1:0] DataOut;
   logic            Valid;
   logic            Overrun;
   logic            FrameErr;
   logic            Busy;

   modport master (
      output SClk, Cs_n, SerIn, Rd,
      input  DataOut, Valid, Overrun, FrameErr, Busy
   );

   modport slave (
      input  SClk, Cs_n, SerIn, Rd,
      output DataOut, Valid, Overrun, FrameErr, Busy
   );
endinterface

// File: rtl/spi_rx.sv
// Mode-0 SPI receiver: words MSB first into a holding register; completion visible 2 Clk after the final SClk rise reaches s1.
// Consumer backpressure is Valid/Rd; a word arriving while Valid is unread is dropped and flagged by sticky Overrun.
module spi_rx #(
   parameter int SIZE = 8
) (
   input  logic     Clk,
   input  logic     Rst,
   spi_rx_if.slave  bus
);
   localparam int CW = (SIZE > 1) ? $clog2(SIZE) : 1;
   localparam logic [CW-1:0] LAST_BIT = CW'(SIZE - 1);

   typedef enum logic [1:0] {
      LOCKOUT = 2'd0,
      IDLE    = 2'd1,
      ACTIVE  = 2'd2
   } state_t;

   state_t          state_q, state_d;

   logic            sclk_s1_q, sclk_s1_d;
   logic            sclk_s2_q, sclk_s2_d;
   logic            sclk_s3_q, sclk_s3_d;
   logic            cs_s1_q, cs_s1_d;
   logic            cs_s2_q, cs_s2_d;
   logic            serin_s1_q, serin_s1_d;
   logic            serin_s2_q, serin_s2_d;

   logic [CW-1:0]   cnt_q, cnt_d;
   logic [SIZE-2:0] shreg_q, shreg_d;
   logic [SIZE-1:0] data_q, data_d;
   logic            valid_q, valid_d;
   logic            overrun_q, overrun_d;
   logic            frame_err_q, frame_err_d;

   logic            rise;
   logic            word_done;
   logic [SIZE-1:0] new_word;

   always_comb begin
      sclk_s1_d  = bus.SClk;
      sclk_s2_d  = sclk_s1_q;
      sclk_s3_d  = sclk_s2_q;
      cs_s1_d    = bus.Cs_n;
      cs_s2_d    = cs_s1_q;
      serin_s1_d = bus.SerIn;
      serin_s2_d = serin_s1_q;
   end

   // serin_s2 is aligned with sclk_s2, so it is the bit present at the detected rise
   assign rise     = sclk_s2_q & ~sclk_s3_q;
   assign new_word = {shreg_q, serin_s2_q};

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      shreg_d     = shreg_q;
      frame_err_d = 1'b0;
      word_done   = 1'b0;
      case (state_q)
         LOCKOUT: begin
            cnt_d = '0;
            if (cs_s2_q) begin
               state_d = IDLE;
            end
         end
         IDLE: begin
            cnt_d = '0;
            if (!cs_s2_q) begin
               state_d = ACTIVE;
            end
         end
         ACTIVE: begin
            if (cs_s2_q) begin
               // deselect ends the frame; any partial word is thrown away
               state_d     = IDLE;
               frame_err_d = (cnt_q != '0);
               cnt_d       = '0;
               shreg_d     = '0;
            end else if (rise) begin
               shreg_d = new_word[SIZE-2:0];
               if (cnt_q == LAST_BIT) begin
                  cnt_d     = '0;
                  word_done = 1'b1;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
         end
         default: begin
            state_d = LOCKOUT;
            cnt_d   = '0;
         end
      endcase
   end

   always_comb begin
      data_d    = data_q;
      valid_d   = valid_q;
      overrun_d = overrun_q;
      if (word_done) begin
         valid_d = 1'b1;
         if (valid_q && !bus.Rd) begin
            overrun_d = 1'b1;
         end else begin
            data_d = new_word;
            if (bus.Rd) begin
               overrun_d = 1'b0;
            end
         end
      end else if (bus.Rd) begin
         valid_d   = 1'b0;
         overrun_d = 1'b0;
      end
   end

   always_ff @(posedge Clk) begin
      if (Rst) begin
         state_q     <= LOCKOUT;
         sclk_s1_q   <= 1'b0;
         sclk_s2_q   <= 1'b0;
         sclk_s3_q   <= 1'b0;
         cs_s1_q     <= 1'b0;
         cs_s2_q     <= 1'b0;
         serin_s1_q  <= 1'b0;
         serin_s2_q  <= 1'b0;
         cnt_q       <= '0;
         shreg_q     <= '0;
         data_q      <= '0;
         valid_q     <= 1'b0;
         overrun_q   <= 1'b0;
         frame_err_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         sclk_s1_q   <= sclk_s1_d;
         sclk_s2_q   <= sclk_s2_d;
         sclk_s3_q   <= sclk_s3_d;
         cs_s1_q     <= cs_s1_d;
         cs_s2_q     <= cs_s2_d;
         serin_s1_q  <= serin_s1_d;
         serin_s2_q  <= serin_s2_d;
         cnt_q       <= cnt_d;
         shreg_q     <= shreg_d;
         data_q      <= data_d;
         valid_q     <= valid_d;
         overrun_q   <= overrun_d;
         frame_err_q <= frame_err_d;
      end
   end

   assign bus.DataOut  = data_q;
   assign bus.Valid    = valid_q;
   assign bus.Overrun  = overrun_q;
   assign bus.FrameErr = frame_err_q;
   assign bus.Busy     = (state_q == ACTIVE);
endmodule

// File: tb/tb_spi_rx.sv
// Bench for spi_rx: directed frames with literal expectations, then random frames against an event-timed model.
module tb_spi_rx;
   localparam int SIZE = 8;

   logic Clk = 1'b0;
   logic Rst;

   spi_rx_if #(.SIZE(SIZE)) bus ();

   spi_rx #(.SIZE(SIZE)) dut (
      .Clk (Clk),
      .Rst (Rst),
      .bus (bus)
   );

   always #5 Clk = ~Clk;

   int checks = 0;
   int errors = 0;
   int edge_no = 0;

   // events keyed by the Clk edge on which they must take effect
   bit              rd_req[int];
   bit              rd_at[int];
   bit              rst_at[int];
   bit              ferr_at[int];
   bit              busy_at[int];
   logic [SIZE-1:0] comp_at[int];

   bit              rand_rd_en = 1'b0;
   bit              locked = 1'b1;
   int              bit_cnt = 0;
   logic [SIZE-1:0] cur_word = '0;

   logic [SIZE-1:0] e_data = '0;
   bit              e_valid = 1'b0;
   bit              e_ovr = 1'b0;
   bit              e_busy = 1'b0;
   bit              e_ferr;
   bit              e_rd;
   int              e;

   always @(posedge Clk) edge_no++;

   initial begin
      bus.Rd = 1'b0;
      forever begin
         @(posedge Clk);
         #1;
         bus.Rd = rd_req.exists(edge_no + 1) || (rand_rd_en && $urandom_range(0, 7) == 0);
      end
   end

   always @(posedge Clk) begin
      #2;
      rd_at[edge_no + 1]  = bus.Rd;
      rst_at[edge_no + 1] = Rst;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at edge %0d: got %0h, expected %0h", name, edge_no, act, exp);
      end
   endtask

   initial begin
      forever begin
         @(negedge Clk);
         e = edge_no;
         e_ferr = 1'b0;
         if (rst_at.exists(e) && rst_at[e]) begin
            e_data  = '0;
            e_valid = 1'b0;
            e_ovr   = 1'b0;
            e_busy  = 1'b0;
         end else begin
            e_rd = rd_at.exists(e) && rd_at[e];
            if (comp_at.exists(e)) begin
               if (e_valid && !e_rd) begin
                  e_ovr = 1'b1;
               end else begin
                  e_data = comp_at[e];
                  if (e_rd) e_ovr = 1'b0;
               end
               e_valid = 1'b1;
            end else if (e_rd) begin
               e_valid = 1'b0;
               e_ovr   = 1'b0;
            end
            if (busy_at.exists(e)) e_busy = busy_at[e];
            e_ferr = ferr_at.exists(e);
         end
         if (e >= 1) begin
            check("DataOut", 32'(bus.DataOut), 32'(e_data));
            check("Valid", 32'(bus.Valid), 32'(e_valid));
            check("Overrun", 32'(bus.Overrun), 32'(e_ovr));
            check("FrameErr", 32'(bus.FrameErr), 32'(e_ferr));
            check("Busy", 32'(bus.Busy), 32'(e_busy));
         end
      end
   end

   initial begin
      #5_000_000;
      errors++;
      $display("FAIL timeout: bench did not finish, errors %0d", errors);
      $fatal(1, "timeout");
   end

   // stimulus edge k is captured by the DUT at k+1; synchronized effects land on k+3
   function automatic bit note_rise(input logic b);
      note_rise = 1'b0;
      if (!locked) begin
         cur_word = {cur_word[SIZE-2:0], b};
         bit_cnt++;
         if (bit_cnt == SIZE) begin
            comp_at[edge_no + 3] = cur_word;
            bit_cnt   = 0;
            note_rise = 1'b1;
         end
      end
   endfunction

   function automatic void note_cs(input logic v);
      if (v) begin
         if (locked) begin
            locked = 1'b0;
         end else begin
            busy_at[edge_no + 3] = 1'b0;
            if (bit_cnt != 0) ferr_at[edge_no + 3] = 1'b1;
         end
         bit_cnt = 0;
      end else if (!locked) begin
         busy_at[edge_no + 3] = 1'b1;
      end
   endfunction

   task automatic tick(input int n);
      repeat (n) @(posedge Clk);
      #1;
   endtask

   task automatic spi_bit(input logic b, input int lo, input int hi, input bit rd_done);
      bus.SerIn = b;
      tick(lo);
      bus.SClk = 1'b1;
      if (note_rise(b) && rd_done) rd_req[edge_no + 3] = 1'b1;
      tick(hi);
      bus.SClk = 1'b0;
   endtask

   task automatic send_word(input logic [SIZE-1:0] w, input int lo, input int hi, input bit rd_done);
      for (int i = SIZE - 1; i >= 0; i--) spi_bit(w[i], lo, hi, rd_done && (i == 0));
   endtask

   task automatic cs_low();
      bus.Cs_n = 1'b0;
      note_cs(1'b0);
      tick(4);
   endtask

   task automatic cs_high();
      tick(3);
      bus.Cs_n = 1'b1;
      note_cs(1'b1);
      tick(6);
   endtask

   task automatic do_reset();
      Rst = 1'b1;
      bit_cnt  = 0;
      cur_word = '0;
      locked   = 1'b1;
      tick(3);
      Rst = 1'b0;
      locked = (bus.Cs_n == 1'b0);
      tick(4);
   endtask

   task automatic do_read();
      int r;
      r = edge_no + 2;
      rd_req[r] = 1'b1;
      while (edge_no < r) @(posedge Clk);
      @(negedge Clk);
      check("read_clears_valid", 32'(bus.Valid), 32'd0);
      check("read_clears_overrun", 32'(bus.Overrun), 32'd0);
      @(posedge Clk);
      #1;
      tick(2);
   endtask

   task automatic lit(input string name, input logic [31:0] act, input logic [31:0] exp);
      @(negedge Clk);
      check(name, act, exp);
      @(posedge Clk);
      #1;
   endtask

   logic [SIZE-1:0] w;
   int k, lo, hi, nw, nb;
   bit part;

   initial begin
      Rst       = 1'b1;
      bus.SClk  = 1'b0;
      bus.Cs_n  = 1'b1;
      bus.SerIn = 1'b0;
      rst_at[1] = 1'b1;
      repeat (2) @(posedge Clk);
      @(negedge Clk);
      check("reset_valid", 32'(bus.Valid), 32'd0);
      check("reset_dataout", 32'(bus.DataOut), 32'd0);
      check("reset_busy", 32'(bus.Busy), 32'd0);
      @(posedge Clk);
      #1;
      Rst = 1'b0;
      locked = 1'b0;
      tick(4);

      // 0xA5 with the last bit timed by hand: Valid rises exactly 3 edges after the rise is driven
      w = 8'hA5;
      cs_low();
      for (int i = SIZE - 1; i >= 1; i--) spi_bit(w[i], 4, 4, 1'b0);
      bus.SerIn = w[0];
      tick(4);
      bus.SClk = 1'b1;
      void'(note_rise(w[0]));
      k = edge_no;
      repeat (3) @(negedge Clk);
      check("latency_valid_early", 32'(bus.Valid), 32'd0);
      @(negedge Clk);
      check("latency_valid_on_time", 32'(bus.Valid), 32'd1);
      check("a5_dataout", 32'(bus.DataOut), 32'hA5);
      @(posedge Clk);
      #1;
      bus.SClk = 1'b0;
      cs_high();
      lit("a5_overrun", 32'(bus.Overrun), 32'd0);
      do_read();

      // two words, no read: second dropped and flagged
      cs_low();
      send_word(8'h3C, 4, 4, 1'b0);
      send_word(8'hC3, 4, 4, 1'b0);
      cs_high();
      lit("ovr_dataout", 32'(bus.DataOut), 32'h3C);
      lit("ovr_flag", 32'(bus.Overrun), 32'd1);
      do_read();

      // read coincident with completion of the second word
      cs_low();
      send_word(8'h12, 4, 4, 1'b0);
      send_word(8'h81, 4, 4, 1'b1);
      cs_high();
      lit("coinc_dataout", 32'(bus.DataOut), 32'h81);
      lit("coinc_valid", 32'(bus.Valid), 32'd1);
      lit("coinc_overrun", 32'(bus.Overrun), 32'd0);

      // frame cut after 5 bits
      cs_low();
      for (int i = 0; i < 5; i++) spi_bit(i[0], 3, 3, 1'b0);
      tick(3);
      bus.Cs_n = 1'b1;
      note_cs(1'b1);
      k = edge_no;
      repeat (3) @(posedge Clk);
      @(negedge Clk);
      check("ferr_pulse", 32'(bus.FrameErr), 32'd1);
      @(negedge Clk);
      check("ferr_single", 32'(bus.FrameErr), 32'd0);
      check("ferr_valid_kept", 32'(bus.Valid), 32'd1);
      @(posedge Clk);
      #1;
      tick(4);
      do_read();
      cs_low();
      send_word(8'h0F, 5, 3, 1'b0);
      cs_high();
      lit("after_ferr_word", 32'(bus.DataOut), 32'h0F);

      // reset three bits into a frame; the rest of that frame must vanish
      cs_low();
      for (int i = 0; i < 3; i++) spi_bit(1'b1, 4, 4, 1'b0);
      do_reset();
      lit("rst_mid_valid", 32'(bus.Valid), 32'd0);
      for (int i = 0; i < 3; i++) spi_bit(1'b1, 4, 4, 1'b0);
      lit("lockout_busy", 32'(bus.Busy), 32'd0);
      for (int i = 0; i < 2; i++) spi_bit(1'b0, 4, 4, 1'b0);
      cs_high();
      lit("lockout_no_word", 32'(bus.Valid), 32'd0);
      cs_low();
      send_word(8'h55, 4, 4, 1'b0);
      cs_high();
      lit("post_lockout_word", 32'(bus.DataOut), 32'h55);
      do_read();

      // random frames, random timing, random reads
      rand_rd_en = 1'b1;
      for (int f = 0; f < 40; f++) begin
         if ($urandom_range(0, 19) == 0) do_reset();
         lo   = $urandom_range(3, 6);
         hi   = $urandom_range(3, 6);
         nw   = $urandom_range(1, 3);
         part = ($urandom_range(0, 4) == 0);
         cs_low();
         for (int j = 0; j < nw; j++) begin
            w = SIZE'($urandom);
            if (part && j == nw - 1) begin
               nb = $urandom_range(1, SIZE - 1);
               for (int b = 0; b < nb; b++) spi_bit(w[b], lo, hi, 1'b0);
            end else begin
               send_word(w, lo, hi, $urandom_range(0, 3) == 0);
            end
         end
         cs_high();
      end
      rand_rd_en = 1'b0;
      tick(10);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
